// File: rtl/spi_cfg_regfile_pkg.sv
// rtl/spi_cfg_regfile_pkg.sv - shared constants, FSM states and register map for the SPI config register file
package spi_cfg_regfile_pkg;

    localparam int CMD_RW_BIT = 7;
    localparam int ADDR_W     = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_t;

    // Register map shared with the decimator, filter and i2s blocks
    localparam logic [ADDR_W-1:0] REG_DEC_RATIO  = 7'd0;
    localparam logic [ADDR_W-1:0] REG_FILT_GAIN  = 7'd1;
    localparam logic [ADDR_W-1:0] REG_FILT_SHIFT = 7'd2;
    localparam logic [ADDR_W-1:0] REG_I2S_CFG    = 7'd3;
    localparam logic [ADDR_W-1:0] REG_I2S_SLOT   = 7'd4;

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return a + 7'd1;
    endfunction

endpackage

// File: rtl/spi_cfg_regfile_if.sv
// rtl/spi_cfg_regfile_if.sv - mode-0 SPI slave bus bundle
interface spi_cfg_regfile_if;

    logic spi_clk;
    logic spi_cs_n;
    logic spi_mosi;
    logic spi_miso;
    logic spi_miso_oe;

    modport master (
        output spi_clk,
        output spi_cs_n,
        output spi_mosi,
        input  spi_miso,
        input  spi_miso_oe
    );

    modport slave (
        input  spi_clk,
        input  spi_cs_n,
        input  spi_mosi,
        output spi_miso,
        output spi_miso_oe
    );

endinterface

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - synchronisers for the SPI inputs plus edge detect on spi_clk
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sclk_async,
    input  logic cs_n_async,
    input  logic mosi_async,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_n_sync,
    output logic mosi_sync
);

    logic [STAGES-1:0] sclk_sr;
    logic [STAGES-1:0] cs_n_sr;
    logic [STAGES-1:0] mosi_sr;
    logic              sclk_prev;

    // Reset to bus idle levels so no edge is seen coming out of reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sr   <= '0;
            cs_n_sr   <= '1;
            mosi_sr   <= '0;
            sclk_prev <= 1'b0;
        end else begin
            sclk_sr   <= {sclk_sr[STAGES-2:0], sclk_async};
            cs_n_sr   <= {cs_n_sr[STAGES-2:0], cs_n_async};
            mosi_sr   <= {mosi_sr[STAGES-2:0], mosi_async};
            sclk_prev <= sclk_sr[STAGES-1];
        end
    end

    assign sclk_rise = sclk_sr[STAGES-1] & ~sclk_prev;
    assign sclk_fall = ~sclk_sr[STAGES-1] & sclk_prev;
    assign cs_n_sync = cs_n_sr[STAGES-1];
    assign mosi_sync = mosi_sr[STAGES-1];

endmodule

// File: rtl/spi_cfg_regfile.sv
// rtl/spi_cfg_regfile.sv - SPI slave configuration register file with read-back and burst auto-increment
module spi_cfg_regfile
    import spi_cfg_regfile_pkg::*;
#(
    parameter int                         DATA_W      = 8,
    parameter int                         NUM_REGS    = 16,
    parameter int                         SYNC_STAGES = 2,
    parameter logic [NUM_REGS*DATA_W-1:0] RST_VALS    = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    spi_cfg_regfile_if.slave             spi,
    output logic [NUM_REGS*DATA_W-1:0]   regs,
    output logic                         wr_strobe,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic                         addr_err
);

    localparam int         IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [7:0] NUM_REGS_L = 8'(NUM_REGS);

    state_t                     state;
    state_t                     state_next;
    logic                       sclk_rise;
    logic                       sclk_fall;
    logic                       cs_n_s;
    logic                       mosi_s;
    logic [2:0]                 bit_cnt;
    logic [DATA_W-1:0]          shift_in;
    logic [DATA_W-1:0]          out_shift;
    logic [DATA_W-1:0]          rx_byte;
    logic [DATA_W-1:0]          rd_data;
    logic                       rw;
    logic                       load_pending;
    logic                       byte_done;
    logic                       in_range;
    logic [ADDR_W-1:0]          addr;
    logic [IDX_W-1:0]           idx;
    logic [NUM_REGS*DATA_W-1:0] regs_q;

    spi_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk        (clk),
        .rst        (rst),
        .sclk_async (spi.spi_clk),
        .cs_n_async (spi.spi_cs_n),
        .mosi_async (spi.spi_mosi),
        .sclk_rise  (sclk_rise),
        .sclk_fall  (sclk_fall),
        .cs_n_sync  (cs_n_s),
        .mosi_sync  (mosi_s)
    );

    assign rx_byte   = {shift_in[DATA_W-2:0], mosi_s};
    assign byte_done = sclk_rise && (bit_cnt == 3'd7);
    assign in_range  = ({1'b0, addr} < NUM_REGS_L);
    assign idx       = addr[IDX_W-1:0];
    assign rd_data   = regs_q[int'(idx)*DATA_W +: DATA_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (!cs_n_s) state_next = CMD;
            CMD: begin
                if (cs_n_s)         state_next = IDLE;
                else if (byte_done) state_next = DATA;
            end
            DATA: if (cs_n_s) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Deselect clears the frame before any bit handling, so an abort coincident
    // with the last bit of a byte never commits that byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q       <= RST_VALS;
            bit_cnt      <= '0;
            shift_in     <= '0;
            out_shift    <= '0;
            rw           <= 1'b0;
            load_pending <= 1'b0;
            addr         <= '0;
            wr_strobe    <= 1'b0;
            wr_addr      <= '0;
            addr_err     <= 1'b0;
        end else begin
            wr_strobe <= 1'b0;
            addr_err  <= 1'b0;
            if (cs_n_s || state == IDLE) begin
                bit_cnt      <= '0;
                load_pending <= 1'b0;
                rw           <= 1'b0;
                out_shift    <= '0;
            end else begin
                if (sclk_rise) begin
                    shift_in <= rx_byte;
                    bit_cnt  <= bit_cnt + 3'd1;
                end
                if (byte_done) begin
                    if (state == CMD) begin
                        rw           <= rx_byte[CMD_RW_BIT];
                        addr         <= rx_byte[ADDR_W-1:0];
                        load_pending <= rx_byte[CMD_RW_BIT];
                    end else if (rw) begin
                        load_pending <= 1'b1;
                    end else begin
                        if (in_range) begin
                            regs_q[int'(idx)*DATA_W +: DATA_W] <= rx_byte;
                            wr_strobe <= 1'b1;
                            wr_addr   <= addr;
                        end else begin
                            addr_err <= 1'b1;
                        end
                        addr <= next_addr(addr);
                    end
                end
                // Reads fetch on the fall that follows a completed byte, so the
                // master sees the MSB before its next sampling rise.
                if (sclk_fall) begin
                    if (load_pending) begin
                        load_pending <= 1'b0;
                        out_shift    <= in_range ? rd_data : '0;
                        addr_err     <= !in_range;
                        addr         <= next_addr(addr);
                    end else begin
                        out_shift <= {out_shift[DATA_W-2:0], 1'b0};
                    end
                end
            end
        end
    end

    assign spi.spi_miso    = out_shift[DATA_W-1];
    assign spi.spi_miso_oe = !cs_n_s && rw;
    assign regs            = regs_q;

endmodule

// File: tb/tb_spi_cfg_regfile.sv
// tb/tb_spi_cfg_regfile.sv - directed frame vectors against a default and a 4-register instance
module tb_spi_cfg_regfile;
    import spi_cfg_regfile_pkg::*;

    typedef struct packed {
        logic        sel;
        logic [2:0]  n;
        logic [47:0] tx;
        logic [47:0] rx;
        logic [2:0]  strobes;
        logic [6:0]  first_wr;
        logic [5:0]  err_mask;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic spi_clk = 1'b0;
    logic cs_a = 1'b1;
    logic cs_b = 1'b1;
    logic mosi = 1'b0;
    logic cur_sel = 1'b0;
    int   cur_byte = 7;
    int   total = 0;
    int   bad = 0;

    logic [127:0] regs_a;
    logic [31:0]  regs_b;
    logic         wrs_a, wrs_b, err_a, err_b;
    logic [6:0]   wra_a, wra_b;
    logic [127:0] model_a;
    logic [31:0]  model_b;

    int         strobe_tot [2];
    logic [6:0] wr_log [2][64];
    int         err_tot [2][8];

    spi_cfg_regfile_if bus_a ();
    spi_cfg_regfile_if bus_b ();

    assign bus_a.spi_clk  = spi_clk;
    assign bus_a.spi_cs_n = cs_a;
    assign bus_a.spi_mosi = mosi;
    assign bus_b.spi_clk  = spi_clk;
    assign bus_b.spi_cs_n = cs_b;
    assign bus_b.spi_mosi = mosi;

    spi_cfg_regfile dut_a (
        .clk       (clk),
        .rst       (rst),
        .spi       (bus_a),
        .regs      (regs_a),
        .wr_strobe (wrs_a),
        .wr_addr   (wra_a),
        .addr_err  (err_a)
    );

    spi_cfg_regfile #(
        .NUM_REGS (4),
        .RST_VALS ({8'h11, 8'h22, 8'h33, 8'h44})
    ) dut_b (
        .clk       (clk),
        .rst       (rst),
        .spi       (bus_b),
        .regs      (regs_b),
        .wr_strobe (wrs_b),
        .wr_addr   (wra_b),
        .addr_err  (err_b)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wrs_a) begin
            wr_log[0][strobe_tot[0] % 64] <= wra_a;
            strobe_tot[0] <= strobe_tot[0] + 1;
        end
        if (wrs_b) begin
            wr_log[1][strobe_tot[1] % 64] <= wra_b;
            strobe_tot[1] <= strobe_tot[1] + 1;
        end
        if (err_a) err_tot[0][cur_byte] <= err_tot[0][cur_byte] + 1;
        if (err_b) err_tot[1][cur_byte] <= err_tot[1][cur_byte] + 1;
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic sel, input int n,
                                input logic [7:0] b0, b1, b2, b3, b4, b5,
                                input logic [7:0] r1, r2, r3, r4, r5,
                                input int strobes, input logic [6:0] fw, input logic [5:0] em);
        vec_t v;
        v.sel      = sel;
        v.n        = 3'(n);
        v.tx       = {b5, b4, b3, b2, b1, b0};
        v.rx       = {r5, r4, r3, r2, r1, 8'h00};
        v.strobes  = 3'(strobes);
        v.first_wr = fw;
        v.err_mask = em;
        return v;
    endfunction

    task automatic xfer_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx, output logic oe_ok);
        rx = '0;
        oe_ok = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            spi_clk = 1'b0;
            mosi = tx[7-i];
            repeat (4) @(negedge clk);
            rx = {rx[6:0], cur_sel ? bus_b.spi_miso : bus_a.spi_miso};
            if (!(cur_sel ? bus_b.spi_miso_oe : bus_a.spi_miso_oe)) oe_ok = 1'b0;
            spi_clk = 1'b1;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic start_frame(input logic sel);
        cur_sel = sel;
        if (sel) cs_b = 1'b0;
        else     cs_a = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic end_frame();
        spi_clk = 1'b0;
        cur_byte = 7;
        repeat (4) @(negedge clk);
        cs_a = 1'b1;
        cs_b = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int          s;
        int          st0;
        int          e0 [8];
        int          ecount;
        logic [47:0] got_rx;
        logic [5:0]  got_err;
        logic        oe_all, ok;
        logic [7:0]  rb;
        logic [6:0]  a;
        int          nreg;
        s = v.sel ? 1 : 0;
        st0 = strobe_tot[s];
        for (int k = 0; k < 8; k++) e0[k] = err_tot[s][k];
        got_rx = '0;
        oe_all = 1'b1;
        start_frame(v.sel);
        for (int k = 0; k < int'(v.n); k++) begin
            cur_byte = k;
            xfer_byte(v.tx[8*k +: 8], 8, rb, ok);
            if (k > 0) begin
                got_rx[8*k +: 8] = rb;
                oe_all = oe_all & ok;
            end
        end
        end_frame();
        ecount = 0;
        for (int k = 0; k < 6; k++) begin
            got_err[k] = (err_tot[s][k] != e0[k]);
            ecount += err_tot[s][k] - e0[k];
        end
        check({name, "/strobes"}, 128'(strobe_tot[s] - st0), 128'(v.strobes));
        if (v.strobes != 0) check({name, "/first_wr_addr"}, 128'(wr_log[s][st0 % 64]), 128'(v.first_wr));
        check({name, "/err_bytes"}, 128'(got_err), 128'(v.err_mask));
        check({name, "/err_count"}, 128'(ecount), 128'($countones(v.err_mask)));
        if (v.tx[7]) begin
            check({name, "/miso_bytes"}, 128'(got_rx), 128'(v.rx));
            check({name, "/miso_oe"}, 128'(oe_all), 128'(1'b1));
        end else begin
            a = v.tx[6:0];
            nreg = s ? 4 : 16;
            for (int k = 1; k < int'(v.n); k++) begin
                if (int'(a) < nreg) begin
                    if (s == 1) model_b[8*int'(a) +: 8] = v.tx[8*k +: 8];
                    else        model_a[8*int'(a) +: 8] = v.tx[8*k +: 8];
                end
                a = a + 7'd1;
            end
        end
        check({name, "/regs"}, s ? 128'(regs_b) : regs_a, s ? 128'(model_b) : model_a);
    endtask

    vec_t  vecs [7];
    string vnames [7];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rb;
        logic       ok;
        int         st0;

        vecs[0] = mk(0, 2, 8'h00, 8'h08, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7'd0, 6'b000000);
        vecs[1] = mk(0, 2, 8'h01, 8'h80, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7'd1, 6'b000000);
        vecs[2] = mk(0, 3, 8'h81, 8'h00, 8'h00, 0, 0, 0, 8'h80, 8'h00, 0, 0, 0, 0, 7'd0, 6'b000000);
        vecs[3] = mk(0, 4, 8'h0E, 8'hAA, 8'hBB, 8'hCC, 0, 0, 0, 0, 0, 0, 0, 2, 7'd14, 6'b001000);
        vecs[4] = mk(0, 4, 8'h8E, 0, 0, 0, 0, 0, 8'hAA, 8'hBB, 8'h00, 0, 0, 0, 7'd0, 6'b001000);
        vecs[5] = mk(0, 3, 8'h7F, 8'h11, 8'h22, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7'd0, 6'b000010);
        vecs[6] = mk(1, 6, 8'h80, 0, 0, 0, 0, 0, 8'h44, 8'h33, 8'h22, 8'h11, 8'h00, 0, 7'd0, 6'b100000);
        vnames = '{"wr_reg0", "wr_reg1", "rd_reg1_burst", "burst_wr_top", "burst_rd_top", "wr_wrap", "small_rd_burst"};

        model_a = '0;
        model_b = 32'h11223344;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset/regs_a", regs_a, model_a);
        check("reset/regs_b", 128'(regs_b), 128'(model_b));
        check("reset/outs_a", 128'({wrs_a, wra_a, err_a, bus_a.spi_miso, bus_a.spi_miso_oe}), 128'(0));
        check("reset/outs_b", 128'({wrs_b, wra_b, err_b, bus_b.spi_miso, bus_b.spi_miso_oe}), 128'(0));

        for (int i = 0; i < 7; i++) run_vec(vecs[i], vnames[i]);

        // Partial byte then deselect: nothing may be written
        st0 = strobe_tot[0];
        start_frame(1'b0);
        cur_byte = 0;
        xfer_byte(8'h03, 8, rb, ok);
        cur_byte = 1;
        xfer_byte(8'hFF, 5, rb, ok);
        end_frame();
        check("partial/strobes", 128'(strobe_tot[0] - st0), 128'(0));
        check("partial/regs", regs_a, model_a);
        run_vec(mk(0, 2, 8'h03, 8'h5A, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7'd3, 6'b0), "wr_after_partial");

        // Reset pulse in the middle of data bit 4
        run_vec(mk(0, 2, 8'h02, 8'h55, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7'd2, 6'b0), "wr_reg2");
        st0 = strobe_tot[0];
        start_frame(1'b0);
        cur_byte = 0;
        xfer_byte(8'h02, 8, rb, ok);
        cur_byte = 1;
        xfer_byte(8'hA5, 4, rb, ok);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        spi_clk = 1'b0;
        cs_a = 1'b1;
        cur_byte = 7;
        repeat (8) @(negedge clk);
        model_a = '0;
        model_b = 32'h11223344;
        check("midrst/strobes", 128'(strobe_tot[0] - st0), 128'(0));
        check("midrst/regs_a", regs_a, model_a);
        check("midrst/regs_b", 128'(regs_b), 128'(model_b));
        run_vec(mk(0, 2, 8'h02, 8'h66, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7'd2, 6'b0), "wr_after_rst");

        check("idle/miso_oe_a", 128'({bus_a.spi_miso, bus_a.spi_miso_oe}), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
